// File: rtl/alu_driver.sv
// Command front end for the combinational ALU: registered issue stage, result capture and tagged response FIFO.
// Optional sticky carry/overflow accumulator is built when ALU_DRV_STICKY_EN is defined.
module alu_driver #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [31:0]                cmd_a,
  input  logic [31:0]                cmd_b,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic [2:0]                 alu_op,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  input  logic [31:0]                alu_y,
  input  logic                       alu_z,
  input  logic                       alu_n,
  input  logic                       alu_c,
  input  logic                       alu_v,
`ifdef ALU_DRV_STICKY_EN
  input  logic                       sticky_clr,
  output logic [1:0]                 sticky_cv,
`endif
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_y,
  output logic [3:0]                 rsp_flags,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 32 + 4 + TAG_W + 1;

  logic             iss_valid_q, iss_valid_d;
  logic [2:0]       iss_op_q, iss_op_d;
  logic [31:0]      iss_a_q, iss_a_d;
  logic [31:0]      iss_b_q, iss_b_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [EW-1:0]    head_q, head_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic          illegal;
  logic [EW-1:0] push_data;

  assign accept    = cmd_valid & cmd_ready_q;
  assign push      = iss_valid_q;
  assign pop       = rsp_valid_q & rsp_ready;
  assign illegal   = iss_op_q[2] & iss_op_q[1];
  assign push_data = {alu_y, alu_z, alu_n, alu_c, alu_v, iss_tag_q, illegal};

  always_comb begin
    iss_valid_d = accept;
    iss_op_d    = accept ? cmd_op  : iss_op_q;
    iss_a_d     = accept ? cmd_a   : iss_a_q;
    iss_b_d     = accept ? cmd_b   : iss_b_q;
    iss_tag_d   = accept ? cmd_tag : iss_tag_q;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // Reserve a slot for the command that would be in the issue stage next cycle.
    cmd_ready_d = ({1'b0, count_d} + {{CW{1'b0}}, iss_valid_d}) < (CW+1)'(DEPTH);
    rsp_valid_d = (count_d != '0);

    // Head register: when the new head slot is being written this edge, forward the capture.
    head_d = head_q;
    if (rsp_valid_d) begin
      if (push && (rd_ptr_d == wr_ptr_q)) head_d = push_data;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_tag_q   <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_tag_q   <= iss_tag_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

`ifdef ALU_DRV_STICKY_EN
  logic [1:0] sticky_cv_q, sticky_cv_d;

  always_comb begin
    sticky_cv_d = sticky_clr ? 2'b00 : sticky_cv_q;
    if (push && !illegal) sticky_cv_d = sticky_cv_d | {alu_c, alu_v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_cv_q <= 2'b00;
    else        sticky_cv_q <= sticky_cv_d;
  end

  assign sticky_cv = sticky_cv_q;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign alu_op      = iss_op_q;
  assign alu_a       = iss_a_q;
  assign alu_b       = iss_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_y       = head_q[EW-1 -: 32];
  assign rsp_flags   = head_q[TAG_W+1 +: 4];
  assign rsp_tag     = head_q[1 +: TAG_W];
  assign rsp_illegal = head_q[0];
  assign count       = count_q;

endmodule

// File: doc/alu_driver.md
# alu_driver

Command-side front end for the `alu` datapath block. It accepts ALU commands over a valid/ready handshake, registers them onto the ALU operand and opcode ports, and captures the ALU result and flags. Tagged responses return through a DEPTH-entry FIFO. It sits between the issue logic and the combinational ALU, so the ALU is always driven from registers and its results are always buffered against consumer back-pressure.

## Interface
Parameters:
- `TAG_W`, 4: width of the command/response tag.
- `DEPTH`, 4: response FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset; asynchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 3: opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT).
- `cmd_a`, `cmd_b` in 32 each: operands.
- `cmd_tag` in TAG_W: opaque tag, returned unchanged.
- `alu_op` out 3: opcode to the ALU.
- `alu_a`, `alu_b` out 32 each: operands to the ALU.
- `alu_y` in 32: ALU result.
- `alu_z`, `alu_n`, `alu_c`, `alu_v` in 1 each: ALU flags.
- `rsp_valid` out 1: response at the FIFO head.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_y` out 32: result.
- `rsp_flags` out 4: flags packed as {z,n,c,v}.
- `rsp_tag` out TAG_W: tag.
- `rsp_illegal` out 1: opcode was 110 or 111.
- `count` out $clog2(DEPTH+1): occupied FIFO entries.
- `sticky_cv` out 2: accumulated {c,v}; present only under the configuration macro.
- `sticky_clr` in 1: clears `sticky_cv`; present only under the configuration macro.

## Operation
- **Issue register.** Holds `iss_valid`, op, a, b, tag.
  - On accept: loads the command and sets `iss_valid`=1.
  - Otherwise: `iss_valid`=0, and op/a/b hold their last values so ALU inputs do not toggle when idle.
- **ALU ports.** `alu_op`/`alu_a`/`alu_b` are driven directly from the issue register.
- **Capture.** In a cycle with `iss_valid`=1, {`alu_y`, `alu_z`, `alu_n`, `alu_c`, `alu_v`, tag, illegal} is written into the FIFO at the end of that cycle.
  - illegal = (op ≥ 3'b110).
  - The ALU output is stored as-is; for an illegal op the ALU produces y=0, z=1.
- **Credit.** A command is accepted only if a FIFO slot is reserved for it: next-state (`count` + `iss_valid`) < DEPTH. No capture is ever dropped.
- **`cmd_ready` is registered.** It is computed from next-state `count` and `iss_valid`, including that cycle's pop.
- **FIFO.**
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; `count` distinguishes full from empty.
  - Simultaneous push and pop leaves `count` unchanged.
  - Pop when empty cannot occur, because `rsp_valid`=0.
- **Response outputs.** The `rsp_*` signals reflect the head entry. When `rsp_valid`=0 they hold their previous values and must not be interpreted.
- **Ordering.** Responses are delivered strictly in command order.

## Timing
- **Reset values:**
  - `cmd_ready`=0, `rsp_valid`=0, `count`=0, `iss_valid`=0.
  - `alu_op`=0, `alu_a`=0, `alu_b`=0.
  - `rsp_y`=0, `rsp_flags`=0, `rsp_tag`=0, `rsp_illegal`=0.
  - `sticky_cv`=0.
- **After reset.** `cmd_ready` rises at the first `clk` edge after `rst_n` deasserts.
- **Latency.** Command accepted at edge N:
  - ALU is driven during cycle N..N+1.
  - The FIFO write happens at edge N+1.
  - `rsp_valid` is 1 after edge N+1 if the FIFO was empty (two edges from accept).
- **Throughput.** One command per cycle while `rsp_ready`=1.
- **Full.** With `rsp_ready` held low, exactly DEPTH commands are accepted, then `cmd_ready`=0. It returns to 1 the edge after the first pop.
- **Reset mid-operation.** The FIFO, the in-flight issue entry and the sticky state are discarded immediately; there are no partial responses.

## Configuration
- **`ALU_DRV_STICKY_EN` defined:**
  - `sticky_cv` ORs {`alu_c`, `alu_v`} of every captured legal-op result.
  - `sticky_clr`=1 clears `sticky_cv` at the next edge.
  - A capture in the same cycle as `sticky_clr` wins: the register is loaded with that capture's {c,v}.
- **`ALU_DRV_STICKY_EN` not defined:** the `sticky_cv` and `sticky_clr` ports and the sticky logic are absent.

## Test plan
- **ADD carry.** ADD a=0xFFFFFFFF, b=1, tag 3 → `rsp_y`=0, `rsp_flags`=4'b1010, `rsp_tag`=3, `rsp_illegal`=0, `rsp_valid` two edges after accept.
- **SUB overflow.** SUB a=0x80000000, b=1 → `rsp_y`=0x7FFFFFFF, `rsp_flags`=4'b0001; with the macro, `sticky_cv`=2'b01 afterwards.
- **Back-to-back ordering.** SLT a=0xFFFFFFFF, b=1 then XOR a=0xF0F0F0F0, b=0xFFFFFFFF, back to back → responses in order: y=1 flags 0000; then y=0x0F0F0F0F flags 0000.
- **Illegal opcode.** op=3'b111, a=5, b=7 → `rsp_y`=0, `rsp_flags`=4'b1000, `rsp_illegal`=1.
- **Full.** `rsp_ready`=0, drive 6 commands → 4 accepted, `count`=4, `cmd_ready`=0. Assert `rsp_ready` for one cycle → one pop, `cmd_ready`=1 next edge, and the 5th command is accepted with its tag in order.
- **Reset mid-operation.** Assert `rst_n`=0 with 3 entries queued → `rsp_valid`=0 and `count`=0 immediately. After release, `cmd_ready`=1 one edge later and no stale response appears.
